// File: rtl/fifo_pace_pkg.sv
// fifo_pace_pkg: shared constants and the pacing FSM state type for fifo_pace_ctrl.
//   CNT_W        width of the downstream fifo_counter load value
//   pace_state_t IDLE / SEND / ARM / WAIT (2-bit encoding)
package fifo_pace_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ARM  = 2'd2,
    WAIT = 2'd3
  } pace_state_t;

endpackage

// File: rtl/fifo_pace_buf.sv
// fifo_pace_buf: word storage, wrap-bit pointers, occupancy and status flags.
//   cpu_clk, cpu_rst_b  clock / async active-low reset (clears pointers)
//   clr                 sync pointer clear (only with FIFO_PACE_FLUSH_EN)
//   push, wr_data       write strobe and word (caller guarantees !fifo_full)
//   pop, rd_data        read strobe (caller guarantees !fifo_empty) and head word
//   fifo_cnt            occupancy, log2(DEPTH)+1 bits
//   fifo_empty/full     status flags
module fifo_pace_buf
  import fifo_pace_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst_b,
`ifdef FIFO_PACE_FLUSH_EN
  input  logic                     clr,
`endif
  input  logic                     push,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     fifo_empty,
  output logic                     fifo_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  // Storage has no reset; contents are don't-care until written.
  always_ff @(posedge cpu_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
    if (!cpu_rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end
`ifdef FIFO_PACE_FLUSH_EN
    else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end
`endif
    else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign rd_data    = mem[rd_ptr[AW-1:0]];
  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/fifo_pace_ctrl.sv
// fifo_pace_ctrl: buffered pacing stage in front of the fifo_counter countdown block.
// Words enter on in_vld/in_rdy, are buffered, and leave one at a time on
// out_vld/out_rdy with a programmable idle gap enforced via fifo_counter.
//   cpu_clk, cpu_rst_b      clock / async active-low reset
//   fifo_flush              sync flush (only with FIFO_PACE_FLUSH_EN defined)
//   in_vld/in_data/in_rdy   upstream handshake; in_rdy = !fifo_full
//   out_vld/out_data/out_rdy downstream handshake; out_data = FIFO head
//   gap_cfg                 idle gap in counter units, latched on each pop
//   counter_en/load/done    fifo_counter control: rising en loads counter_load
//   fifo_cnt/empty/full     buffer status
// Optional feature macro: FIFO_PACE_FLUSH_EN.
module fifo_pace_ctrl
  import fifo_pace_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst_b,
`ifdef FIFO_PACE_FLUSH_EN
  input  logic                     fifo_flush,
`endif
  input  logic                     in_vld,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_rdy,
  output logic                     out_vld,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_rdy,
  input  logic [CNT_W-1:0]         gap_cfg,
  output logic                     counter_en,
  output logic [CNT_W-1:0]         counter_load,
  input  logic                     counter_done,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     fifo_empty,
  output logic                     fifo_full
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  pace_state_t       state;
  logic              out_vld_q;
  logic              cen_q;
  logic [CNT_W-1:0]  gap_q;
  logic              push;
  logic              pop;
  logic              more;

`ifdef FIFO_PACE_FLUSH_EN
  assign in_rdy  = !fifo_full && !fifo_flush;
  assign out_vld = out_vld_q && !fifo_flush;
`else
  assign in_rdy  = !fifo_full;
  assign out_vld = out_vld_q;
`endif

  assign push = in_vld && in_rdy;
  assign pop  = out_vld && out_rdy;
  // A word remains after this pop if more than one is stored or one arrives now.
  assign more = (fifo_cnt > CNT_ONE) || push;

  assign counter_en   = cen_q;
  assign counter_load = gap_q;

  fifo_pace_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .cpu_clk    (cpu_clk),
    .cpu_rst_b  (cpu_rst_b),
`ifdef FIFO_PACE_FLUSH_EN
    .clr        (fifo_flush),
`endif
    .push       (push),
    .wr_data    (in_data),
    .pop        (pop),
    .rd_data    (out_data),
    .fifo_cnt   (fifo_cnt),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
  );

  // out_vld and counter_en are registered alongside the state so they never
  // glitch; counter_done is only looked at in WAIT because it is still high
  // from the previous count while ARM raises counter_en.
  always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
    if (!cpu_rst_b) begin
      state     <= IDLE;
      out_vld_q <= 1'b0;
      cen_q     <= 1'b0;
      gap_q     <= '0;
    end
`ifdef FIFO_PACE_FLUSH_EN
    else if (fifo_flush) begin
      state     <= IDLE;
      out_vld_q <= 1'b0;
      cen_q     <= 1'b0;
    end
`endif
    else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state     <= SEND;
            out_vld_q <= 1'b1;
          end
        end
        SEND: begin
          if (pop) begin
            gap_q <= gap_cfg;
            if (gap_cfg != '0) begin
              state     <= ARM;
              out_vld_q <= 1'b0;
              cen_q     <= 1'b1;
            end else if (!more) begin
              state     <= IDLE;
              out_vld_q <= 1'b0;
            end
          end
        end
        ARM: begin
          state <= WAIT;
        end
        WAIT: begin
          if (counter_done) begin
            cen_q <= 1'b0;
            if (!fifo_empty) begin
              state     <= SEND;
              out_vld_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_vld_q <= 1'b0;
          cen_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pace_ctrl.sv
module tb_fifo_pace_ctrl;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_b;
`ifdef FIFO_PACE_FLUSH_EN
  logic        fifo_flush;
`endif
  logic        in_vld;
  logic [31:0] in_data;
  logic        in_rdy;
  logic        out_vld;
  logic [31:0] out_data;
  logic        out_rdy;
  logic [31:0] gap_cfg;
  logic        counter_en;
  logic [31:0] counter_load;
  logic        counter_done;
  logic [3:0]  fifo_cnt;
  logic        fifo_empty;
  logic        fifo_full;

  fifo_pace_ctrl #(.DATA_W(32), .DEPTH(8)) dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst_b    (cpu_rst_b),
`ifdef FIFO_PACE_FLUSH_EN
    .fifo_flush   (fifo_flush),
`endif
    .in_vld       (in_vld),
    .in_data      (in_data),
    .in_rdy       (in_rdy),
    .out_vld      (out_vld),
    .out_data     (out_data),
    .out_rdy      (out_rdy),
    .gap_cfg      (gap_cfg),
    .counter_en   (counter_en),
    .counter_load (counter_load),
    .counter_done (counter_done),
    .fifo_cnt     (fifo_cnt),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full)
  );

  always #5 cpu_clk = ~cpu_clk;

  int cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  // Behavioural fifo_counter: loads on a rising counter_en, counts down to zero.
  logic [31:0] cnt_q;
  logic        prev_en;
  int          cen_rises = 0;
  assign counter_done = (cnt_q == 32'd0);
  always @(posedge cpu_clk or negedge cpu_rst_b) begin
    if (!cpu_rst_b) begin
      cnt_q   <= 32'd0;
      prev_en <= 1'b0;
    end else begin
      prev_en <= counter_en;
      if (counter_en && !prev_en) begin
        cnt_q     <= counter_load;
        cen_rises <= cen_rises + 1;
      end else if (cnt_q != 32'd0) begin
        cnt_q <= cnt_q - 32'd1;
      end
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // Monitor: every output handshake must match the next expected word and cycle.
  always @(negedge cpu_clk) begin
    if (cpu_rst_b && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL hs_unexpected: got data 0x%0h expected no handshake (cycle %0d)", out_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hs_data", out_data, e.data);
        check("hs_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int d;
    int e;
    int r0;
    cpu_rst_b = 1'b0;
`ifdef FIFO_PACE_FLUSH_EN
    fifo_flush = 1'b0;
`endif
    in_vld  = 1'b0;
    in_data = '0;
    out_rdy = 1'b0;
    gap_cfg = '0;

    // Reset values
    repeat (2) @(negedge cpu_clk);
    check("rst_out_vld", out_vld, 0);
    check("rst_cen", counter_en, 0);
    check("rst_load", counter_load, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_cnt", fifo_cnt, 0);
    check("rst_in_rdy", in_rdy, 1);
    cpu_rst_b = 1'b1;

    // Zero gap: back-to-back, counter never armed
    gap_cfg = 0;
    out_rdy = 1'b1;
    r0 = cen_rises;
    tick(); c = cyc;
    in_vld = 1'b1; in_data = 32'hA5; sb.push_back('{32'hA5, c + 2});
    tick();
    in_data = 32'h5A; sb.push_back('{32'h5A, c + 3});
    tick();
    in_vld = 1'b0;
    repeat (6) tick();
    check("zg_no_cen", cen_rises - r0, 0);

    // Full and backpressure
    out_rdy = 1'b0;
    tick(); c = cyc;
    for (int i = 0; i < 9; i++) begin
      in_vld  = 1'b1;
      in_data = 32'h100 + 32'(i);
      if (i == 8) begin
        @(negedge cpu_clk);
        check("full_in_rdy", in_rdy, 0);
        check("full_cnt", fifo_cnt, 8);
        check("full_flag", fifo_full, 1);
        check("hold_vld", out_vld, 1);
        check("hold_data", out_data, 32'h100);
      end
      tick();
    end
    in_vld = 1'b0;
    tick(); d = cyc;
    out_rdy = 1'b1; sb.push_back('{32'h100, d});
    tick();
    out_rdy = 1'b0;
    @(negedge cpu_clk);
    check("bp_in_rdy", in_rdy, 1);
    check("bp_cnt", fifo_cnt, 7);
    tick(); e = cyc;
    out_rdy = 1'b1;
    for (int k = 1; k < 8; k++) sb.push_back('{32'h100 + 32'(k), e + k - 1});
    repeat (10) tick();
    check("drain_empty", fifo_empty, 1);

    // Nonzero gap of 5: L+2 = 7 idle cycles between handshakes
    gap_cfg = 5;
    r0 = cen_rises;
    tick(); c = cyc;
    in_vld = 1'b1; in_data = 32'h11; sb.push_back('{32'h11, c + 2});
    tick();
    in_data = 32'h22; sb.push_back('{32'h22, c + 10});
    tick();
    in_data = 32'h33; sb.push_back('{32'h33, c + 18});
    tick();
    in_vld = 1'b0;
    tick();
    @(negedge cpu_clk);
    check("gap_cen", counter_en, 1);
    check("gap_load", counter_load, 5);
    repeat (25) tick();
    check("gap_rises", cen_rises - r0, 3);
    check("gap_idle_cen", counter_en, 0);

    // Config change during WAIT, then reset during WAIT
    gap_cfg = 5;
    tick(); c = cyc;
    in_vld = 1'b1; in_data = 32'h44; sb.push_back('{32'h44, c + 2});
    tick();
    in_data = 32'h55; sb.push_back('{32'h55, c + 10});
    tick();
    in_data = 32'h66;
    tick();
    in_vld = 1'b0;
    tick();
    gap_cfg = 1;
    tick();
    @(negedge cpu_clk);
    check("cfg_load_kept", counter_load, 5);
    repeat (7) tick();
    @(negedge cpu_clk);
    check("cfg_wait_cen", counter_en, 1);
    check("cfg_new_load", counter_load, 1);
    #1 cpu_rst_b = 1'b0;
    #1;
    check("arst_cen", counter_en, 0);
    check("arst_empty", fifo_empty, 1);
    check("arst_vld", out_vld, 0);
    check("arst_cnt", fifo_cnt, 0);
    check("arst_sb", sb.size(), 0);
    @(negedge cpu_clk);
    cpu_rst_b = 1'b1;

`ifdef FIFO_PACE_FLUSH_EN
    // Flush with 4 words buffered and a push pending
    gap_cfg = 0;
    out_rdy = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_data = 32'h71 + 32'(i);
      tick();
    end
    in_data = 32'h99;
    fifo_flush = 1'b1;
    @(negedge cpu_clk);
    check("fl_in_rdy", in_rdy, 0);
    check("fl_vld", out_vld, 0);
    check("fl_cnt_before", fifo_cnt, 4);
    tick();
    fifo_flush = 1'b0;
    in_vld = 1'b0;
    @(negedge cpu_clk);
    check("fl_cnt_after", fifo_cnt, 0);
    check("fl_empty", fifo_empty, 1);
    repeat (2) tick();
    @(negedge cpu_clk);
    check("fl_idle_vld", out_vld, 0);
`endif

    repeat (3) tick();
    check("sb_final", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
